boot_sequencer: RTL and testbench

// Synthesizable boot controller that sits in front of proc.
// - Holds the core in reset for a programmable count.
// - Streams words from a valid/ready source into the imem or dmem preload write port.
// - Releases the core and counts run cycles.
// - Ends the run on halt or on a watchdog timeout, and reports status.
// It replaces ad-hoc bench-side file preload and reset counting, so that FPGA and simulation share one boot path.

---
 rtl/boot_sequencer_if.sv | 26 ++
 rtl/boot_sequencer.sv | 109 ++++++++++
 tb/tb_boot_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_sequencer_if.sv
// Stream-in / preload-write bundle between an image source, the boot sequencer
// and the core's memory preload port.
interface boot_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_last;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data, in_sel, in_last,
    output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, in_sel, in_last,
    input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot controller: holds the core in reset, streams an image into imem/dmem,
// releases the core and supervises the run with an optional watchdog.
module boot_sequencer #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 16,
  parameter int IMEM_SIZE_BYTES = 64,
  parameter int DMEM_SIZE_BYTES = 32,
  parameter int N_RESET         = 10,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int CNT_W           = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  boot_sequencer_if.slave      bus,
  input  logic                 i_core_halt,
  output logic                 o_core_reset_n,
  output logic [CNT_W-1:0]     o_cycle_cnt,
  output logic [2:0]           o_state
);
  localparam int BPW    = DATA_W / 8;
  localparam int HOLD_W = $clog2(N_RESET + 1);

  typedef enum logic [2:0] {
    S_HOLD = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2,
    S_DONE = 3'd3, S_TIMEOUT = 3'd4, S_ERROR = 3'd5
  } state_t;

  state_t              r_state, w_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [ADDR_W-1:0]   r_iptr, r_dptr;
  logic                r_mem_we, r_mem_sel;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_core_rst_n;
  logic [CNT_W-1:0]    r_cycle_cnt;

  logic                w_accept, w_ovf, w_tmo;
  logic [ADDR_W-1:0]   w_ptr;
  logic [ADDR_W:0]     w_ptr_nxt, w_lim;

  assign bus.in_ready = (r_state == S_LOAD);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_ptr        = bus.in_sel ? r_dptr : r_iptr;
  // One extra bit so the end-of-region compare cannot wrap.
  assign w_ptr_nxt    = {1'b0, w_ptr} + (ADDR_W+1)'(BPW);
  assign w_lim        = bus.in_sel ? (ADDR_W+1)'(DMEM_SIZE_BYTES) : (ADDR_W+1)'(IMEM_SIZE_BYTES);
  assign w_ovf        = w_ptr_nxt > w_lim;
  assign w_tmo        = (TIMEOUT_CYCLES != 0) && (r_cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_HOLD;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HOLD: if (r_hold_cnt == HOLD_W'(N_RESET - 1)) w_next = S_LOAD;
      S_LOAD: begin
        if (w_accept) begin
          if (w_ovf)            w_next = S_ERROR;
          else if (bus.in_last) w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (i_core_halt) w_next = S_DONE;
        else if (w_tmo)  w_next = S_TIMEOUT;
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold_cnt   <= '0;
      r_iptr       <= '0;
      r_dptr       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_sel    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rst_n <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      if (w_accept && !w_ovf) begin
        r_mem_we    <= 1'b1;
        r_mem_sel   <= bus.in_sel;
        r_mem_addr  <= w_ptr;
        r_mem_wdata <= bus.in_data;
        if (bus.in_sel) r_dptr <= w_ptr_nxt[ADDR_W-1:0];
        else            r_iptr <= w_ptr_nxt[ADDR_W-1:0];
      end
      // Release lags RUN entry by a cycle; drop lags the terminal state by a cycle.
      r_core_rst_n <= (r_state == S_RUN);
      if (r_state == S_RUN && r_core_rst_n && w_next == S_RUN && r_cycle_cnt != '1)
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_sel    = r_mem_sel;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign o_core_reset_n = r_core_rst_n;
  assign o_cycle_cnt    = r_cycle_cnt;
  assign o_state        = r_state;
endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: expected preload writes go into a queue,
// a negedge monitor pops and compares every mem_we the DUT issues.
module tb_boot_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_halt = 1'b0;
  logic        core_reset_n;
  logic [31:0] cycle_cnt;
  logic [2:0]  state;

  typedef struct packed {
    logic        sel;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t got_w, exp_w;

  always #5 clk = ~clk;

  boot_sequencer_if #(.DATA_W(32), .ADDR_W(16)) bus();

  boot_sequencer #(
    .DATA_W(32), .ADDR_W(16), .IMEM_SIZE_BYTES(64), .DMEM_SIZE_BYTES(32),
    .N_RESET(10), .TIMEOUT_CYCLES(100), .CNT_W(32)
  ) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus), .i_core_halt(core_halt),
    .o_core_reset_n(core_reset_n), .o_cycle_cnt(cycle_cnt), .o_state(state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_w = {bus.mem_sel, bus.mem_addr, bus.mem_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got sel=%0d addr=%h data=%h want no write",
                 got_w.sel, got_w.addr, got_w.data);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL mem_write got sel=%0d addr=%h data=%h want sel=%0d addr=%h data=%h",
                   got_w.sel, got_w.addr, got_w.data, exp_w.sel, exp_w.addr, exp_w.data);
        end
      end
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic s, input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w = {s, a, d};
    exp_q.push_back(w);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
  task automatic send(input logic [31:0] d, input logic s, input logic l,
                      input bit wr, input logic [15:0] a);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout got in_ready=%b want 1", bus.in_ready);
    end else if (wr) begin
      push(s, a, d);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    core_halt    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_load();
    int n = 0;
    while (state !== 3'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_load", state, 3'd1);
  endtask

  initial begin
    int n;
    bit bad;
    int k;
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit bad;
    int k;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);

    // Reset values, hold length; halt must be ignored outside RUN
    reset = 1'b1;
    core_halt = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_core_reset_n", core_reset_n, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_cycle_cnt", cycle_cnt, 32'h0);
    reset = 1'b0;
    n = 0;
    bad = 1'b0;
    while (state === 3'd0 && n < 50) begin
      if (core_reset_n !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", n, 10);
    chk("hold_core_reset_n", bad, 1'b0);
    chk("load_state", state, 3'd1);
    chk("load_in_ready", bus.in_ready, 1'b1);
    core_halt = 1'b0;

    // Back-to-back mixed-region beats
    wr_cyc.delete();
    send(32'h00500093, 1'b0, 1'b0, 1'b1, 16'h00);
    send(32'h00000013, 1'b0, 1'b0, 1'b1, 16'h04);
    send(32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 16'h00);
    chk("t2_state_run", state, 3'd2);
    chk("t2_in_ready_low", bus.in_ready, 1'b0);
    chk("t2_core_reset_n_lag", core_reset_n, 1'b0);
    @(negedge clk);
    chk("t2_core_released", core_reset_n, 1'b1);
    chk("t2_mem_we_low", bus.mem_we, 1'b0);
    chk("t2_addr_hold", bus.mem_addr, 16'h00);
    chk("t2_wdata_hold", bus.mem_wdata, 32'hDEADBEEF);
    k = wr_cyc.size();
    chk("t2_write_count", k, 3);
    chk("t2_consecutive", (k >= 3) ? (wr_cyc[k-1] - wr_cyc[k-3]) : -1, 2);

    // Gappy valid, fill imem exactly
    do_reset();
    wait_load();
    wr_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      send(32'h10000000 + i, 1'b0, (i == 15), 1'b1, 16'(i * 4));
      if (i != 15) @(negedge clk);
    end
    @(negedge clk);
    chk("t3_state_run", state, 3'd2);
    chk("t3_write_count", wr_cyc.size(), 16);

    // dmem overflow on the 9th beat
    do_reset();
    wait_load();
    wr_cyc.delete();
    for (int i = 0; i < 9; i++)
      send(32'hA0 + i, 1'b1, 1'b0, (i < 8), 16'(i * 4));
    chk("t4_state_error", state, 3'd5);
    chk("t4_in_ready_low", bus.in_ready, 1'b0);
    chk("t4_mem_we_low", bus.mem_we, 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_core_reset_n", core_reset_n, 1'b0);
    chk("t4_sticky", state, 3'd5);
    chk("t4_write_count", wr_cyc.size(), 8);

    // Watchdog expiry
    do_reset();
    wait_load();
    send(32'h00000013, 1'b0, 1'b1, 1'b1, 16'h00);
    n = 0;
    while (state === 3'd2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_state_timeout", state, 3'd4);
    chk("t5_cnt", cycle_cnt, 32'd99);
    chk("t5_core_reset_n_lag", core_reset_n, 1'b1);
    @(negedge clk);
    chk("t5_core_reset_n_fall", core_reset_n, 1'b0);
    chk("t5_cnt_frozen", cycle_cnt, 32'd99);

    // Halt on the last watchdog cycle wins
    do_reset();
    wait_load();
    send(32'h00000013, 1'b0, 1'b1, 1'b1, 16'h00);
    n = 0;
    while (cycle_cnt !== 32'd99 && state === 3'd2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    chk("t5b_state_done", state, 3'd3);
    chk("t5b_cnt", cycle_cnt, 32'd99);
    @(negedge clk);
    chk("t5b_core_reset_n_fall", core_reset_n, 1'b0);
    chk("t5b_sticky", state, 3'd3);

    // Reset mid-LOAD clears pointers
    do_reset();
    wait_load();
    send(32'h11111111, 1'b0, 1'b0, 1'b1, 16'h00);
    send(32'h22222222, 1'b0, 1'b0, 1'b1, 16'h04);
    send(32'h33333333, 1'b0, 1'b0, 1'b1, 16'h08);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_state_hold", state, 3'd0);
    chk("t6_addr_cleared", bus.mem_addr, 16'h00);
    reset = 1'b0;
    wait_load();
    send(32'h55555555, 1'b0, 1'b1, 1'b1, 16'h00);
    @(negedge clk);
    chk("t6_state_run", state, 3'd2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
